register_file_mp: RTL and testbench
===================================

# register_file_mp

Multi-ported MIPS register file: N_READ combinational read ports, one write port, register 0 hardwired to zero, a per-register pending-write scoreboard for hazard detection, and a handshaked dump engine that streams every register to the debug unit. It sits in the decode stage, with the write port driven by writeback and the dump port driven by the debug/UART controller.

## Interface
- NB_ADDR, 5, register address width
- NB_DATA, 32, register width
- N_READ, 2, number of read ports (≥1)
- RAM_DEPTH, 2**NB_ADDR, number of registers
- i_clock  in  1  clock, all state on rising edge
- i_reset_n  in  1  synchronous active-low reset
- i_write_enable  in  1  writeback strobe
- i_write_addr  in  NB_ADDR  write address
- i_data  in  NB_DATA  write data
- i_read_addr  in  N_READ*NB_ADDR  packed read addresses, port k at bits [k*NB_ADDR +: NB_ADDR]
- o_read_data  out  N_READ*NB_DATA  packed read data, same packing
- o_read_busy  out  N_READ  per-port "pending write outstanding" flag
- i_reserve  in  1  mark i_reserve_addr as pending (issue of a producer)
- i_reserve_addr  in  NB_ADDR  register being reserved
- i_dump_start  in  1  start a full dump
- i_dump_ready  in  1  consumer accepts current dump beat
- o_dump_valid  out  1  dump beat valid
- o_dump_addr  out  NB_ADDR  index of current beat
- o_dump_data  out  NB_DATA  contents of o_dump_addr
- o_dump_done  out  1  one-cycle pulse after last beat accepted

## Operation
- Reset (i_reset_n=0 at edge): all registers 0, all busy bits 0, dump FSM to IDLE, o_dump_valid=0, o_dump_done=0, o_dump_addr=0.
- Write: i_write_enable=1 at edge stores i_data at i_write_addr and clears busy[i_write_addr]. Writes to address 0 discarded; rf[0] and busy[0] always 0.
- Read: o_read_data port k = rf[addr_k], combinational; address 0 always returns 0.
- Scoreboard: i_reserve=1 sets busy[i_reserve_addr] at edge (ignored for address 0). Reserve and write to the same address in one cycle: reserve wins (busy stays 1, data written). o_read_busy[k] = busy[addr_k].
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: i_dump_start=1 → SEND, index=0. Otherwise stay.
  - SEND: o_dump_valid=1, o_dump_addr=index, o_dump_data=rf[index] (live, combinational). On i_dump_ready: index==RAM_DEPTH-1 → DONE, else index+1. No ready → hold.
  - DONE: o_dump_done=1 for one cycle → IDLE.
  - i_dump_start ignored outside IDLE. Writes and reserves proceed normally during a dump; a beat reflects contents at the cycle it is accepted.
- Index counter is NB_ADDR wide; terminal compare, not wrap, ends the dump.

## Timing
- Read/busy latency: combinational, 0 cycles from address.
- Write visible on read ports the cycle after the edge (no bypass build); same cycle with bypass build.
- Dump: first beat valid cycle after start edge; with ready held high, RAM_DEPTH beats in RAM_DEPTH consecutive cycles, o_dump_done next cycle, IDLE the cycle after; new start accepted from IDLE.
- Reset mid-dump aborts with no o_dump_done.

## Configuration
- REGFILE_BYPASS_EN defined: read port k with i_write_enable=1, i_write_addr==addr_k≠0 returns i_data and o_read_busy[k]=i_reserve&&i_reserve_addr==addr_k (write-through forwarding, busy cleared same cycle). Dump data is not bypassed.
- Undefined: reads return stored contents only; busy reflects registered bits.

## Structure
- Shared package: dump state encoding (IDLE/SEND/DONE), default NB_ADDR/NB_DATA constants, REG_ZERO address constant.
- One sub-module: regfile_dump_fsm (state + index counter, handshake outputs); storage, scoreboard and read ports stay in the top.

## Test plan
- Reset, then read all ports at addr 3, 31 → data 0, busy 0; write 0xDEADBEEF to addr 0 → reads 0.
- Write 0x12345678 to addr 5, read addr 5 same cycle → old value 0 (no bypass) / 0x12345678 (bypass); next cycle 0x12345678 on both ports.
- Reserve addr 7 → o_read_busy=1 next cycle; write addr 7 → busy 0 next cycle; reserve+write addr 7 same cycle → busy stays 1, data updated.
- Load rf[i]=i*3, start dump with ready high → 32 beats addr 0..31 data 0..93, o_dump_done one cycle later, exactly once.
- Dump with ready toggling every other cycle → each beat held stable until accepted, 32 beats total; i_dump_start mid-dump has no effect.
- Assert i_reset_n=0 at beat 10 → valid drops next cycle, no done pulse, registers zero; fresh dump afterwards starts at addr 0.

Source files
------------

// File: rtl/register_file_mp_pkg.sv
// Shared definitions for register_file_mp: default widths, the hardwired zero
// register index and the dump engine state encoding.
package register_file_mp_pkg;

  localparam int unsigned NB_ADDR_DEF = 5;
  localparam int unsigned NB_DATA_DEF = 32;
  localparam int unsigned REG_ZERO    = 0;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_SEND = 2'd1,
    DUMP_DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/register_file_mp_dump_fsm.sv
// Dump engine for register_file_mp: walks the register index from 0 to
// RAM_DEPTH-1 under a valid/ready handshake, then pulses done for one cycle.
module regfile_dump_fsm
  import register_file_mp_pkg::*;
#(
  parameter int NB_ADDR   = NB_ADDR_DEF,
  parameter int RAM_DEPTH = 2 ** NB_ADDR
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_dump_start,
  input  logic               i_dump_ready,
  output logic               o_dump_valid,
  output logic [NB_ADDR-1:0] o_dump_addr,
  output logic               o_dump_done,
  output dump_state_e        o_state
);

  // Handshake: a beat transfers on a rising edge where valid and ready are
  // both high; while valid is high and ready is low, addr (and the data the
  // top derives from it) holds.
  localparam logic [NB_ADDR-1:0] LAST_IDX = NB_ADDR'(RAM_DEPTH - 1);

  dump_state_e        state_q, state_d;
  logic [NB_ADDR-1:0] idx_q, idx_d;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q <= DUMP_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    o_dump_valid = 1'b0;
    o_dump_done  = 1'b0;
    case (state_q)
      DUMP_IDLE: begin
        if (i_dump_start) begin
          state_d = DUMP_SEND;
          idx_d   = '0;
        end
      end
      DUMP_SEND: begin
        o_dump_valid = 1'b1;
        if (i_dump_ready) begin
          // Terminal compare ends the dump; the counter never wraps into a second pass.
          if (idx_q == LAST_IDX) begin
            state_d = DUMP_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DUMP_DONE: begin
        o_dump_done = 1'b1;
        state_d     = DUMP_IDLE;
      end
      default: begin
        state_d = DUMP_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign o_dump_addr = idx_q;
  assign o_state     = state_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-ported register file with hardwired zero register, pending-write
// scoreboard and a streaming dump port. Define REGFILE_BYPASS_EN for
// write-through forwarding on the read ports.
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int NB_ADDR   = NB_ADDR_DEF,
  parameter int NB_DATA   = NB_DATA_DEF,
  parameter int N_READ    = 2,
  parameter int RAM_DEPTH = 2 ** NB_ADDR
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic                      i_write_enable,
  input  logic [NB_ADDR-1:0]        i_write_addr,
  input  logic [NB_DATA-1:0]        i_data,
  input  logic [N_READ*NB_ADDR-1:0] i_read_addr,
  output logic [N_READ*NB_DATA-1:0] o_read_data,
  output logic [N_READ-1:0]         o_read_busy,
  input  logic                      i_reserve,
  input  logic [NB_ADDR-1:0]        i_reserve_addr,
  input  logic                      i_dump_start,
  input  logic                      i_dump_ready,
  output logic                      o_dump_valid,
  output logic [NB_ADDR-1:0]        o_dump_addr,
  output logic [NB_DATA-1:0]        o_dump_data,
  output logic                      o_dump_done
);

  localparam logic [NB_ADDR-1:0] ZERO_ADDR = NB_ADDR'(REG_ZERO);

  logic [NB_DATA-1:0]   rf_q [RAM_DEPTH];
  logic [RAM_DEPTH-1:0] busy_q, busy_d;
  logic                 wr_ok;
  dump_state_e          dump_state;

  assign wr_ok = i_write_enable && (i_write_addr != ZERO_ADDR);

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      for (int i = 0; i < RAM_DEPTH; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wr_ok) begin
      rf_q[i_write_addr] <= i_data;
    end
  end

  // Reserve is applied after the write clear so a same-cycle reserve wins.
  always_comb begin
    busy_d = busy_q;
    if (i_write_enable) begin
      busy_d[i_write_addr] = 1'b0;
    end
    if (i_reserve) begin
      busy_d[i_reserve_addr] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < N_READ; k++) begin : g_read
    logic [NB_ADDR-1:0] addr_k;
    logic [NB_DATA-1:0] stored_k;
    assign addr_k   = i_read_addr[k*NB_ADDR +: NB_ADDR];
    assign stored_k = (addr_k == ZERO_ADDR) ? '0 : rf_q[addr_k];
`ifdef REGFILE_BYPASS_EN
    logic hit_k;
    assign hit_k = wr_ok && (i_write_addr == addr_k);
    assign o_read_data[k*NB_DATA +: NB_DATA] = hit_k ? i_data : stored_k;
    assign o_read_busy[k] = hit_k ? (i_reserve && (i_reserve_addr == addr_k))
                                  : busy_q[addr_k];
`else
    assign o_read_data[k*NB_DATA +: NB_DATA] = stored_k;
    assign o_read_busy[k] = busy_q[addr_k];
`endif
  end

  regfile_dump_fsm #(
    .NB_ADDR  (NB_ADDR),
    .RAM_DEPTH(RAM_DEPTH)
  ) u_dump (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_dump_start(i_dump_start),
    .i_dump_ready(i_dump_ready),
    .o_dump_valid(o_dump_valid),
    .o_dump_addr (o_dump_addr),
    .o_dump_done (o_dump_done),
    .o_state     (dump_state)
  );

  // Dump data is live storage contents, never forwarded from the write port.
  assign o_dump_data = rf_q[o_dump_addr];

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp; expected values follow the bypass
// build when REGFILE_BYPASS_EN is defined.
module tb_register_file_mp;

  localparam int NB_ADDR = 5;
  localparam int NB_DATA = 32;
  localparam int N_READ  = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic                      we;
  logic [NB_ADDR-1:0]        wa;
  logic [NB_DATA-1:0]        wd;
  logic [N_READ*NB_ADDR-1:0] ra;
  logic [N_READ*NB_DATA-1:0] rd;
  logic [N_READ-1:0]         rbusy;
  logic                      reserve;
  logic [NB_ADDR-1:0]        res_addr;
  logic                      dstart;
  logic                      dready;
  logic                      dvalid;
  logic [NB_ADDR-1:0]        daddr;
  logic [NB_DATA-1:0]        ddata;
  logic                      ddone;

  int tests_run    = 0;
  int tests_failed = 0;

  register_file_mp #(
    .NB_ADDR(NB_ADDR),
    .NB_DATA(NB_DATA),
    .N_READ (N_READ)
  ) dut (
    .i_clock       (clk),
    .i_reset_n     (reset_n),
    .i_write_enable(we),
    .i_write_addr  (wa),
    .i_data        (wd),
    .i_read_addr   (ra),
    .o_read_data   (rd),
    .o_read_busy   (rbusy),
    .i_reserve     (reserve),
    .i_reserve_addr(res_addr),
    .i_dump_start  (dstart),
    .i_dump_ready  (dready),
    .o_dump_valid  (dvalid),
    .o_dump_addr   (daddr),
    .o_dump_data   (ddata),
    .o_dump_done   (ddone)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after a rising edge; outputs are checked on falling edges.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [NB_ADDR-1:0] a, input logic [NB_DATA-1:0] d);
    we = 1'b1; wa = a; wd = d;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = '0;
    reserve = 1'b0; res_addr = '0; dstart = 1'b0; dready = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    ra = {5'd31, 5'd3};
    @(negedge clk);
    tests_run++;
    if (rd !== 64'h0) begin tests_failed++; $display("FAIL reset_read_data got %h exp %h", rd, 64'h0); end
    tests_run++;
    if (rbusy !== 2'b00) begin tests_failed++; $display("FAIL reset_busy got %b exp 00", rbusy); end
    tests_run++;
    if (dvalid !== 1'b0 || ddone !== 1'b0 || daddr !== 5'd0) begin
      tests_failed++; $display("FAIL reset_dump got v=%b d=%b a=%0d exp v=0 d=0 a=0", dvalid, ddone, daddr);
    end
    tick();
    write_reg(5'd0, 32'hDEADBEEF);
    ra = {5'd0, 5'd0};
    @(negedge clk);
    tests_run++;
    if (rd !== 64'h0) begin tests_failed++; $display("FAIL write_addr0 got %h exp %h", rd, 64'h0); end
    tick();
  endtask

  task automatic test_write();
    logic [N_READ*NB_DATA-1:0] exp_same;
    exp_same = BYP ? {32'h12345678, 32'h12345678} : 64'h0;
    we = 1'b1; wa = 5'd5; wd = 32'h12345678; ra = {5'd5, 5'd5};
    @(negedge clk);
    tests_run++;
    if (rd !== exp_same) begin tests_failed++; $display("FAIL write_same_cycle got %h exp %h", rd, exp_same); end
    tick();
    we = 1'b0;
    @(negedge clk);
    tests_run++;
    if (rd !== {32'h12345678, 32'h12345678}) begin
      tests_failed++; $display("FAIL write_next_cycle got %h exp %h", rd, {32'h12345678, 32'h12345678});
    end
    tick();
  endtask

  task automatic test_scoreboard();
    logic [1:0]         exp_b;
    logic [NB_DATA-1:0] exp_d;
    ra = {5'd0, 5'd7};
    reserve = 1'b1; res_addr = 5'd7;
    tick();
    reserve = 1'b0;
    @(negedge clk);
    tests_run++;
    if (rbusy !== 2'b01) begin tests_failed++; $display("FAIL reserve_busy got %b exp 01", rbusy); end
    tick();
    we = 1'b1; wa = 5'd7; wd = 32'h77;
    exp_b = BYP ? 2'b00 : 2'b01;
    @(negedge clk);
    tests_run++;
    if (rbusy !== exp_b) begin tests_failed++; $display("FAIL write_busy_same_cycle got %b exp %b", rbusy, exp_b); end
    tick();
    we = 1'b0;
    @(negedge clk);
    tests_run++;
    if (rbusy !== 2'b00 || rd[31:0] !== 32'h77) begin
      tests_failed++; $display("FAIL write_clears_busy got b=%b d=%h exp b=00 d=77", rbusy, rd[31:0]);
    end
    tick();
    we = 1'b1; wa = 5'd7; wd = 32'hABC; reserve = 1'b1; res_addr = 5'd7;
    exp_b = BYP ? 2'b01 : 2'b00;
    exp_d = BYP ? 32'hABC : 32'h77;
    @(negedge clk);
    tests_run++;
    if (rbusy !== exp_b || rd[31:0] !== exp_d) begin
      tests_failed++; $display("FAIL reserve_write_same_cycle got b=%b d=%h exp b=%b d=%h", rbusy, rd[31:0], exp_b, exp_d);
    end
    tick();
    we = 1'b0; reserve = 1'b0;
    @(negedge clk);
    tests_run++;
    if (rbusy !== 2'b01 || rd[31:0] !== 32'hABC) begin
      tests_failed++; $display("FAIL reserve_wins got b=%b d=%h exp b=01 d=abc", rbusy, rd[31:0]);
    end
    tick();
    reserve = 1'b1; res_addr = 5'd0;
    tick();
    reserve = 1'b0;
    @(negedge clk);
    tests_run++;
    if (rbusy !== 2'b01) begin tests_failed++; $display("FAIL reserve_addr0 got %b exp 01", rbusy); end
    tick();
  endtask

  task automatic test_dump_full();
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i * 3));
    dstart = 1'b1;
    tick();
    dstart = 1'b0; dready = 1'b1;
    for (int b = 0; b < 32; b++) begin
      @(negedge clk);
      tests_run++;
      if (dvalid !== 1'b1 || daddr !== 5'(b) || ddata !== 32'(b * 3) || ddone !== 1'b0) begin
        tests_failed++;
        $display("FAIL dump_beat_%0d got v=%b a=%0d d=%0d done=%b exp v=1 a=%0d d=%0d done=0",
                 b, dvalid, daddr, ddata, ddone, b, b * 3);
      end
      tick();
    end
    @(negedge clk);
    tests_run++;
    if (dvalid !== 1'b0 || ddone !== 1'b1) begin
      tests_failed++; $display("FAIL dump_done_pulse got v=%b done=%b exp v=0 done=1", dvalid, ddone);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (dvalid !== 1'b0 || ddone !== 1'b0) begin
      tests_failed++; $display("FAIL dump_done_once got v=%b done=%b exp v=0 done=0", dvalid, ddone);
    end
    tick();
    dready = 1'b0;
  endtask

  task automatic test_dump_toggle();
    int  exp_idx;
    bit  done_seen;
    dstart = 1'b1;
    tick();
    dstart = 1'b0;
    exp_idx = 0;
    done_seen = 1'b0;
    for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
      dready = (cyc % 2 == 1);
      dstart = (cyc == 6 || cyc == 7);
      @(negedge clk);
      if (ddone === 1'b1) begin
        done_seen = 1'b1;
        tests_run++;
        if (exp_idx != 32 || dvalid !== 1'b0) begin
          tests_failed++; $display("FAIL toggle_beat_count got %0d v=%b exp 32 v=0", exp_idx, dvalid);
        end
      end else begin
        tests_run++;
        if (dvalid !== 1'b1 || daddr !== 5'(exp_idx) || ddata !== 32'(exp_idx * 3)) begin
          tests_failed++;
          $display("FAIL toggle_beat got v=%b a=%0d d=%0d exp v=1 a=%0d d=%0d",
                   dvalid, daddr, ddata, exp_idx, exp_idx * 3);
        end
        if (dready) exp_idx++;
      end
      tick();
    end
    dstart = 1'b0; dready = 1'b0;
    tests_run++;
    if (!done_seen) begin tests_failed++; $display("FAIL toggle_timeout got no done exp done within 200 cycles"); end
    @(negedge clk);
    tests_run++;
    if (dvalid !== 1'b0 || ddone !== 1'b0) begin
      tests_failed++; $display("FAIL toggle_idle_after got v=%b done=%b exp 0 0", dvalid, ddone);
    end
    tick();
  endtask

  task automatic test_reset_mid_dump();
    bit done_seen;
    dready = 1'b1; dstart = 1'b1;
    tick();
    dstart = 1'b0;
    for (int b = 0; b < 10; b++) tick();
    @(negedge clk);
    tests_run++;
    if (dvalid !== 1'b1 || daddr !== 5'd10) begin
      tests_failed++; $display("FAIL mid_dump_beat10 got v=%b a=%0d exp v=1 a=10", dvalid, daddr);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (dvalid !== 1'b0 || ddone !== 1'b0) begin
      tests_failed++; $display("FAIL mid_dump_abort got v=%b done=%b exp 0 0", dvalid, ddone);
    end
    done_seen = 1'b0;
    dready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      if (ddone === 1'b1) done_seen = 1'b1;
    end
    tests_run++;
    if (done_seen) begin tests_failed++; $display("FAIL abort_no_done got done=1 exp done=0"); end
    ra = {5'd31, 5'd3};
    @(negedge clk);
    tests_run++;
    if (rd !== 64'h0 || rbusy !== 2'b00) begin
      tests_failed++; $display("FAIL abort_regs_zero got d=%h b=%b exp d=0 b=00", rd, rbusy);
    end
    tick();
    dstart = 1'b1; dready = 1'b1;
    tick();
    dstart = 1'b0;
    @(negedge clk);
    tests_run++;
    if (dvalid !== 1'b1 || daddr !== 5'd0 || ddata !== 32'h0) begin
      tests_failed++; $display("FAIL fresh_dump_first got v=%b a=%0d d=%h exp v=1 a=0 d=0", dvalid, daddr, ddata);
    end
    done_seen = 1'b0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      tick();
      @(negedge clk);
      if (ddone === 1'b1) done_seen = 1'b1;
    end
    tests_run++;
    if (!done_seen) begin tests_failed++; $display("FAIL fresh_dump_timeout got no done exp done within 40 cycles"); end
    tick();
    dready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_scoreboard();
    test_dump_full();
    test_dump_toggle();
    test_reset_mid_dump();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
